// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings and default widths for the CPU instruction/data memory arbiter.
package cpu_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: data wins unless the instruction side has waited through a full streak.
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = 3
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_data
);

  always_comb begin
    grant_data = 1'b0;
    if (data_req) begin
      grant_data = !inst_req || (streak < STREAK_W'(STARVE_LIMIT));
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bridge port between IF and MEM stages.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]          state;
  logic                owner;
  logic [STREAK_W-1:0] streak;
  logic                grant_data;
  logic                idle;
  logic                resp;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STREAK_W     (STREAK_W)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .streak     (streak),
    .grant_data (grant_data)
  );

  // Acceptance is gated by resetn so no addr_ok escapes while reset is held.
  always_comb begin
    idle         = (state == ST_IDLE) && resetn;
    data_addr_ok = idle && grant_data;
    inst_addr_ok = idle && inst_req && !grant_data;
    resp         = (state == ST_WAIT) && mem_data_ok;
    inst_data_ok = resp && (owner == OWN_INST);
    data_data_ok = resp && (owner == OWN_DATA);
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;
    mem_req      = (state == ST_REQ);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      owner     <= OWN_INST;
      streak    <= '0;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_addr_ok) begin
            state     <= ST_REQ;
            owner     <= OWN_DATA;
            mem_wr    <= data_wr;
            mem_size  <= data_size;
            mem_wstrb <= data_wstrb;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            if (!inst_req) begin
              streak <= '0;
            end else if (streak != STREAK_W'(STARVE_LIMIT)) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (inst_addr_ok) begin
            state     <= ST_REQ;
            owner     <= OWN_INST;
            mem_wr    <= 1'b0;
            mem_size  <= SIZE_WORD;
            mem_wstrb <= '0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end
        end
        ST_REQ: begin
          if (mem_addr_ok) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_data_ok) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter using immediate assertions.
module tb_cpu_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [5:0] pat;

  cpu_mem_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_addr   = 32'h1c000000;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;

    // Reset state, with inst_req already high
    tick;
    tick;
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_fields", {25'd0, mem_wr, mem_size, mem_wstrb}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // Inst only
    resetn = 1'b1;
    settle;
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    tick;
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    settle;
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h1c000000);
    chk("t1_mem_wr_size", {29'd0, mem_wr, mem_size}, 32'd2);
    tick;
    mem_addr_ok = 1'b0;
    settle;
    chk("t1_wait_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t1_wait_no_ok", {31'd0, inst_data_ok}, 32'd0);
    tick;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h02800400;
    settle;
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h02800400);
    chk("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("t1_data_rdata", data_rdata, 32'h0);
    tick;
    settle;
    chk("idle_stray_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("idle_stray_rdata", inst_rdata, 32'h0);
    mem_data_ok = 1'b0;

    // Simultaneous: data store wins, inst follows
    inst_req   = 1'b1;
    inst_addr  = 32'h1c000004;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_wstrb = 4'hf;
    data_addr  = 32'h00000100;
    data_wdata = 32'hdeadbeef;
    settle;
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick;
    data_req = 1'b0;
    settle;
    chk("t2_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t2_mem_wstrb", {28'd0, mem_wstrb}, 32'hf);
    chk("t2_mem_addr", mem_addr, 32'h00000100);
    chk("t2_mem_wdata", mem_wdata, 32'hdeadbeef);
    chk("t2_req_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h55aa55aa;
    settle;
    chk("t2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("t2_wait_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    tick;
    mem_data_ok = 1'b0;
    settle;
    chk("t2_inst_granted", {31'd0, inst_addr_ok}, 32'd1);
    tick;
    inst_req = 1'b0;
    settle;
    chk("t2_inst_mem_addr", mem_addr, 32'h1c000004);
    chk("t2_inst_mem_fields", {25'd0, mem_wr, mem_size, mem_wstrb}, 32'h20);
    chk("t2_inst_mem_wdata", mem_wdata, 32'h0);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h12340000;
    settle;
    chk("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    tick;
    mem_data_ok = 1'b0;

    // Starvation: both held high, grants D,D,D,D,I,D (bit=1 means data)
    pat        = 6'b101111;
    inst_req   = 1'b1;
    inst_addr  = 32'h1c000010;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_addr  = 32'h00000200;
    for (int i = 0; i < 6; i++) begin
      settle;
      chk($sformatf("t3_data_grant%0d", i), {31'd0, data_addr_ok}, {31'd0, pat[i]});
      chk($sformatf("t3_inst_grant%0d", i), {31'd0, inst_addr_ok}, {31'd0, !pat[i]});
      tick;
      mem_addr_ok = 1'b1;
      tick;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      settle;
      chk($sformatf("t3_owner_ok%0d", i), {30'd0, data_data_ok, inst_data_ok},
          pat[i] ? 32'd2 : 32'd1);
      tick;
      mem_data_ok = 1'b0;
    end
    inst_req = 1'b0;
    data_req = 1'b0;

    // Backpressure: half store held in REQ for 5 cycles
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd1;
    data_wstrb = 4'h3;
    data_addr  = 32'h00000300;
    data_wdata = 32'h12345678;
    settle;
    chk("t4_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick;
    data_req   = 1'b0;
    data_addr  = 32'hffffffff;
    data_wdata = 32'h0;
    data_wstrb = 4'h0;
    inst_req   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("t4_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t4_mem_addr", mem_addr, 32'h00000300);
      chk("t4_mem_wdata", mem_wdata, 32'h12345678);
      chk("t4_mem_wstrb_size", {26'd0, mem_size, mem_wstrb}, 32'h13);
      chk("t4_no_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      tick;
    end
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    settle;
    chk("t4_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    tick;
    mem_data_ok = 1'b0;

    // Reset in WAIT, then stray response
    inst_req  = 1'b1;
    inst_addr = 32'h1c000008;
    tick;
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    resetn      = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hcafef00d;
    settle;
    chk("t5_rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_rst_mem_addr", mem_addr, 32'h0);
    tick;
    resetn = 1'b1;
    settle;
    chk("t5_stray_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t5_stray_rdata", inst_rdata, 32'h0);
    mem_data_ok = 1'b0;
    inst_req    = 1'b1;
    settle;
    chk("t5_idle_accept", {31'd0, inst_addr_ok}, 32'd1);
    inst_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one SRAM-like memory port between the IF-stage instruction requester and the MEM-stage data requester.
- Sits between the pipeline stages and the memory bridge.
- Holds one transaction in flight, latches the winning request, and routes the response back to its owner.
- Uses fixed data-over-instruction priority, with a starvation guard for the instruction side.

Parameters:
- STARVE_LIMIT, 4: consecutive contested data grants after which a pending instruction request wins.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; one clock, asynchronous, active-low.
- inst_req  in  1  instruction read request; held by IF until inst_addr_ok.
- inst_addr  in  ADDR_W  instruction fetch address.
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok  out  1  instruction read data valid this cycle.
- inst_rdata  out  DATA_W  instruction read data.
- data_req  in  1  data request; held by MEM until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  DATA_W/8  byte strobes for stores.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  load data valid, or store complete, this cycle.
- data_rdata  out  DATA_W  load data.
- mem_req  out  1  request to memory bridge.
- mem_wr  out  1  latched write flag.
- mem_size  out  2  latched size.
- mem_wstrb  out  DATA_W/8  latched strobes.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_addr_ok  in  1  bridge accepted mem_req.
- mem_data_ok  in  1  bridge response valid.
- mem_rdata  in  DATA_W  bridge read data.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, owner = INST, streak = 0.
  - All latched mem_* fields = 0.
  - Every output = 0.
- States: IDLE, REQ, WAIT.
- IDLE, grant selection (combinational):
  - Only one requester high: grant it.
  - Both high: grant data if streak < STARVE_LIMIT, otherwise grant inst.
- IDLE, acceptance:
  - The granted side's *_addr_ok is 1 in the same cycle (combinational). The other side's addr_ok is 0.
  - On that edge: latch owner and the request fields (inst grant: wr=0, size=2, wstrb=0, wdata=0), then go to REQ.
- Streak update at grant:
  - Data granted while inst_req is also high: streak += 1, saturating at STARVE_LIMIT.
  - Inst granted: streak = 0.
  - Data granted with inst_req low: streak = 0.
- REQ:
  - mem_req = 1, driven only from registers; no combinational path from inst_* or data_* to mem_*.
  - On mem_addr_ok go to WAIT; otherwise hold all fields stable.
- WAIT:
  - mem_req = 0.
  - On mem_data_ok: the owner's *_data_ok = 1 for exactly that cycle; *_rdata = mem_rdata (combinational pass-through); go to IDLE.
  - The non-owner's data_ok is 0.
- Outside WAIT:
  - mem_data_ok is ignored.
  - inst_rdata and data_rdata are 0.
- Latency:
  - Accept in cycle 0; mem_req in cycle 1 (mem_addr_ok same cycle at best); data_ok in cycle 2 at best.
  - The next accept is possible in the cycle after data_ok.
- One outstanding transaction only: *_addr_ok is never asserted outside IDLE.
- A requester that drops *_req before *_addr_ok loses nothing; no state changes.
- Reset asserted mid-transaction returns to IDLE immediately. Any later stray mem_data_ok is discarded because state is no longer WAIT.
- Stores complete through the same WAIT/data_ok path, with rdata don't-care.

Decomposition:
- Shared package contains:
  - State encoding constants: IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2.
  - Owner encoding: INST = 0, DATA = 1.
  - Size encodings.
  - ADDR_W and DATA_W defaults.
- One natural sub-module: mem_arb_pick, the combinational grant logic (inputs inst_req, data_req, streak; output grant_data).
- FSM, latches and streak counter stay in the top level.

Test Plan:
- Inst only: inst_addr=0x1c000000, bridge returns 0x02800400 after 2 WAIT cycles. Expect inst_addr_ok in cycle 0, mem_req with mem_addr=0x1c000000 in cycle 1, inst_data_ok with inst_rdata=0x02800400, data_data_ok stays 0.
- Simultaneous requests: inst 0x1c000004, data store to 0x00000100, wdata 0xdeadbeef, wstrb 4'hf. Expect data granted first (mem_wr=1, mem_wstrb=4'hf); inst granted only after data_data_ok.
- Starvation: data_req and inst_req held high continuously, STARVE_LIMIT=4. Expect grants D,D,D,D,I,D,…, with streak reset to 0 after the I grant.
- Backpressure: mem_addr_ok held low 5 cycles in REQ. Expect mem_addr, mem_wdata and mem_wstrb stable, no addr_ok on either side, transaction completes normally afterwards.
- Reset mid-WAIT: assert resetn=0 for 1 cycle during WAIT, then mem_data_ok pulses. Expect all outputs 0, no *_data_ok, state IDLE.
